// File: rtl/ri_mc_ctrl_pkg.sv
// Shared control definitions for the RI multi-cycle core: FSM states, ALU codes,
// opcode/func constants and the decoded control bundle.
package ri_defs;

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_IF   = 3'b001,
        S_ID   = 3'b010,
        S_EX   = 3'b011,
        S_WB   = 3'b100
    } state_t;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_XOR  = 3'b010,
        ALU_NOR  = 3'b011,
        ALU_ADD  = 3'b100,
        ALU_SUB  = 3'b101,
        ALU_SLTU = 3'b110,
        ALU_SLL  = 3'b111
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    typedef struct packed {
        logic    rd_rt_s;
        logic    rt_imm_s;
        logic    imm_s;
        logic    rs_shamt;
        alu_op_t alu_op;
    } ctrl_t;

endpackage

// File: rtl/ri_decode.sv
// Combinational instruction decoder: opcode/func to control bundle plus legal flag.
// Unsupported encodings yield an all-zero bundle with legal=0.
module ri_decode
    import ri_defs::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output ctrl_t      ctrl,
    output logic       legal
);

    always_comb begin
        ctrl  = '0;
        legal = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (func)
                    FN_ADD:  ctrl.alu_op = ALU_ADD;
                    FN_SUB:  ctrl.alu_op = ALU_SUB;
                    FN_AND:  ctrl.alu_op = ALU_AND;
                    FN_OR:   ctrl.alu_op = ALU_OR;
                    FN_XOR:  ctrl.alu_op = ALU_XOR;
                    FN_NOR:  ctrl.alu_op = ALU_NOR;
                    FN_SLTU: ctrl.alu_op = ALU_SLTU;
                    FN_SLLV: ctrl.alu_op = ALU_SLL;
                    FN_SLL: begin
                        ctrl.alu_op   = ALU_SLL;
                        ctrl.rs_shamt = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                ctrl.rd_rt_s  = 1'b1;
                ctrl.rt_imm_s = 1'b1;
                // Arithmetic immediates are sign-extended, logical ones zero-extended.
                case (opcode)
                    OP_ADDI:  begin ctrl.alu_op = ALU_ADD;  ctrl.imm_s = 1'b1; end
                    OP_SLTIU: begin ctrl.alu_op = ALU_SLTU; ctrl.imm_s = 1'b1; end
                    OP_ANDI:  ctrl.alu_op = ALU_AND;
                    OP_ORI:   ctrl.alu_op = ALU_OR;
                    default:  ctrl.alu_op = ALU_XOR;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/ri_mc_ctrl.sv
// Multi-cycle control FSM (IDLE/IF/ID/EX/WB). Every output comes straight from a
// flop: strobes are computed alongside the next state so they line up with it.
module ri_mc_ctrl
    import ri_defs::*;
#(
    parameter int unsigned FETCH_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output logic       PC_Write,
    output logic       IR_Write,
    output logic       Reg_Write,
    output logic       FR_Write,
    output logic       rd_rt_s,
    output logic       rt_imm_s,
    output logic       imm_s,
    output logic       rs_shamt,
    output logic [2:0] ALU_OP,
    output logic       ill_inst,
    output logic [2:0] state
);

    localparam logic [2:0] FW = 3'(FETCH_WAIT);

    state_t     cur, nxt;
    logic [2:0] wait_cnt, wait_nxt;
    logic       ir_nxt, fr_nxt, reg_nxt, ill_nxt;
    logic       boundary;
    ctrl_t      ctrl_q, ctrl_nxt, dec_ctrl;
    logic       dec_legal;

    ri_decode u_decode (
        .opcode (opcode),
        .func   (func),
        .ctrl   (dec_ctrl),
        .legal  (dec_legal)
    );

    always_comb begin
        nxt      = cur;
        wait_nxt = wait_cnt;
        ir_nxt   = 1'b0;
        fr_nxt   = 1'b0;
        reg_nxt  = 1'b0;
        ill_nxt  = 1'b0;
        boundary = 1'b0;
        ctrl_nxt = ctrl_q;
        case (cur)
            S_IDLE: boundary = 1'b1;
            S_IF: begin
                if (wait_cnt == FW) begin
                    nxt = S_ID;
                end else begin
                    wait_nxt = wait_cnt + 3'd1;
                    ir_nxt   = (wait_cnt + 3'd1 == FW);
                end
            end
            S_ID: begin
                ctrl_nxt = dec_ctrl;
                if (dec_legal) begin
                    nxt    = S_EX;
                    fr_nxt = 1'b1;
                end else begin
                    ill_nxt  = 1'b1;
                    boundary = 1'b1;
                end
            end
            S_EX: begin
                nxt     = S_WB;
                reg_nxt = 1'b1;
            end
            S_WB: boundary = 1'b1;
            default: nxt = S_IDLE;
        endcase
        // Instruction boundary: idle, retired, or rejected -- run decides whether to fetch.
        if (boundary) begin
            nxt      = run ? S_IF : S_IDLE;
            wait_nxt = '0;
            ir_nxt   = run && (FW == 3'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur       <= S_IDLE;
            wait_cnt  <= '0;
            PC_Write  <= 1'b0;
            IR_Write  <= 1'b0;
            FR_Write  <= 1'b0;
            Reg_Write <= 1'b0;
            ill_inst  <= 1'b0;
            ctrl_q    <= '0;
        end else begin
            cur       <= nxt;
            wait_cnt  <= wait_nxt;
            PC_Write  <= ir_nxt;
            IR_Write  <= ir_nxt;
            FR_Write  <= fr_nxt;
            Reg_Write <= reg_nxt;
            ill_inst  <= ill_nxt;
            ctrl_q    <= ctrl_nxt;
        end
    end

    assign rd_rt_s  = ctrl_q.rd_rt_s;
    assign rt_imm_s = ctrl_q.rt_imm_s;
    assign imm_s    = ctrl_q.imm_s;
    assign rs_shamt = ctrl_q.rs_shamt;
    assign ALU_OP   = ctrl_q.alu_op;
    assign state    = cur;

endmodule

// File: tb/tb_ri_mc_ctrl.sv
// Bench for ri_mc_ctrl: two instances (FETCH_WAIT=0 and 1) checked every cycle
// against a position-in-instruction model, plus directed literal checks.
module tb_ri_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       run [2];
    logic [5:0] op  [2];
    logic [5:0] fn  [2];
    logic       pcw [2], irw [2], rgw [2], frw [2], ill [2];
    logic       rdrt [2], rtim [2], imms [2], rssh [2];
    logic [2:0] alu [2], st [2];

    int asserts = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    ri_mc_ctrl #(.FETCH_WAIT(0)) u_dut0 (
        .clk(clk), .rst(rst), .run(run[0]), .opcode(op[0]), .func(fn[0]),
        .PC_Write(pcw[0]), .IR_Write(irw[0]), .Reg_Write(rgw[0]), .FR_Write(frw[0]),
        .rd_rt_s(rdrt[0]), .rt_imm_s(rtim[0]), .imm_s(imms[0]), .rs_shamt(rssh[0]),
        .ALU_OP(alu[0]), .ill_inst(ill[0]), .state(st[0])
    );

    ri_mc_ctrl #(.FETCH_WAIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .run(run[1]), .opcode(op[1]), .func(fn[1]),
        .PC_Write(pcw[1]), .IR_Write(irw[1]), .Reg_Write(rgw[1]), .FR_Write(frw[1]),
        .rd_rt_s(rdrt[1]), .rt_imm_s(rtim[1]), .imm_s(imms[1]), .rs_shamt(rssh[1]),
        .ALU_OP(alu[1]), .ill_inst(ill[1]), .state(st[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Instruction table: {legal, rd_rt_s, rt_imm_s, imm_s, rs_shamt, alu_op[2:0]}
    function automatic logic [7:0] ref_decode(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h00: case (f)
                6'h20: return 8'b1_0000_100;
                6'h22: return 8'b1_0000_101;
                6'h24: return 8'b1_0000_000;
                6'h25: return 8'b1_0000_001;
                6'h26: return 8'b1_0000_010;
                6'h27: return 8'b1_0000_011;
                6'h2B: return 8'b1_0000_110;
                6'h04: return 8'b1_0000_111;
                6'h00: return 8'b1_0001_111;
                default: return 8'h00;
            endcase
            6'h08: return 8'b1_1110_100;
            6'h0B: return 8'b1_1110_110;
            6'h0C: return 8'b1_1100_000;
            6'h0D: return 8'b1_1100_001;
            6'h0E: return 8'b1_1100_010;
            default: return 8'h00;
        endcase
    endfunction

    // Model: busy flag, cycle position k since fetch start, last decoded bundle.
    bit         started = 1'b0;
    bit         m_busy [2] = '{1'b0, 1'b0};
    int         m_k    [2] = '{0, 0};
    bit         m_ill  [2] = '{1'b0, 1'b0};
    logic [6:0] m_ctrl [2] = '{7'd0, 7'd0};

    always @(posedge clk) begin
        started <= 1'b1;
        for (int i = 0; i < 2; i++) begin
            automatic int         fw = i;
            automatic bit         b  = m_busy[i];
            automatic int         kk = m_k[i];
            automatic bit         il = 1'b0;
            automatic logic [6:0] c  = m_ctrl[i];
            automatic logic [7:0] d;
            if (rst) begin
                b = 1'b0; kk = 0; c = '0;
            end else if (!b) begin
                if (run[i]) begin b = 1'b1; kk = 0; end
            end else if (kk == fw + 1) begin
                d = ref_decode(op[i], fn[i]);
                c = d[6:0];
                if (!d[7]) begin il = 1'b1; b = run[i]; kk = 0; end
                else kk++;
            end else if (kk == fw + 3) begin
                b = run[i]; kk = 0;
            end else begin
                kk++;
            end
            m_busy[i] <= b;
            m_k[i]    <= kk;
            m_ill[i]  <= il;
            m_ctrl[i] <= c;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                automatic int          fw = i;
                automatic int          k  = m_k[i];
                automatic bit          b  = m_busy[i];
                automatic logic [2:0]  es;
                automatic logic        eir, efr, erg;
                automatic logic [14:0] ev, av;
                es  = !b ? 3'd0 : (k <= fw) ? 3'd1 : (k == fw + 1) ? 3'd2 : (k == fw + 2) ? 3'd3 : 3'd4;
                eir = b && (k == fw);
                efr = b && (k == fw + 2);
                erg = b && (k == fw + 3);
                ev  = {es, eir, eir, erg, efr, m_ill[i], m_ctrl[i]};
                av  = {st[i], pcw[i], irw[i], rgw[i], frw[i], ill[i],
                       rdrt[i], rtim[i], imms[i], rssh[i], alu[i]};
                chk($sformatf("dut%0d outputs", i), 32'(av), 32'(ev));
                chk($sformatf("dut%0d strobe exclusivity", i),
                    32'((32'(irw[i]) + 32'(frw[i]) + 32'(rgw[i])) <= 1), 32'd1);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_state(input int i, input logic [2:0] s, input string name);
        bit found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            @(negedge clk);
            if (st[i] === s) found = 1'b1;
        end
        if (!found) chk({name, " timeout"}, 32'(st[i]), 32'(s));
    endtask

    task automatic run_one(input logic [5:0] o, input logic [5:0] f, input string name);
        op[1] = o; fn[1] = f; run[1] = 1'b1;
        wait_state(1, 3'd3, name);
        run[1] = 1'b0;
    endtask

    int regs;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin run[i] = 1'b0; op[i] = '0; fn[i] = '0; end
        repeat (2) cyc();
        rst = 1'b0;

        for (int c = 0; c < 10; c++) begin
            cyc();
            chk("idle state", 32'(st[1]), 32'd0);
            chk("idle outputs", 32'({pcw[1], irw[1], rgw[1], frw[1], ill[1], rdrt[1], rtim[1],
                                      imms[1], rssh[1], alu[1]}), 32'd0);
        end

        // add with FETCH_WAIT=1; run dropped early must not abort the instruction
        op[1] = 6'h00; fn[1] = 6'h20; run[1] = 1'b1;
        cyc(); chk("add c1 state", 32'(st[1]), 32'd1); chk("add c1 IR", 32'(irw[1]), 32'd0);
        run[1] = 1'b0;
        cyc(); chk("add c2 state", 32'(st[1]), 32'd1); chk("add c2 IR/PC", 32'({irw[1], pcw[1]}), 32'd3);
        cyc(); chk("add c3 state", 32'(st[1]), 32'd2);
        cyc(); chk("add c4 state", 32'(st[1]), 32'd3); chk("add c4 FR", 32'(frw[1]), 32'd1);
        chk("add ALU_OP", 32'(alu[1]), 32'd4); chk("add rd_rt_s", 32'(rdrt[1]), 32'd0);
        cyc(); chk("add c5 state", 32'(st[1]), 32'd4); chk("add c5 Reg", 32'(rgw[1]), 32'd1);
        cyc(); chk("add then idle", 32'(st[1]), 32'd0);

        run_one(6'h08, 6'h00, "addi");
        chk("addi ctrl", 32'({rdrt[1], rtim[1], imms[1], rssh[1], alu[1]}), 32'b1110_100);
        wait_state(1, 3'd0, "addi idle");
        run_one(6'h0C, 6'h00, "andi");
        chk("andi imm_s", 32'(imms[1]), 32'd0); chk("andi ALU_OP", 32'(alu[1]), 32'd0);
        wait_state(1, 3'd0, "andi idle");
        run_one(6'h00, 6'h00, "sll");
        chk("sll rs_shamt", 32'(rssh[1]), 32'd1); chk("sll ALU_OP", 32'(alu[1]), 32'd7);
        wait_state(1, 3'd0, "sll idle");

        // illegal func 001000 with run held high
        op[1] = 6'h00; fn[1] = 6'h08; run[1] = 1'b1;
        wait_state(1, 3'd2, "illegal ID");
        cyc();
        chk("illegal ill_inst", 32'(ill[1]), 32'd1);
        chk("illegal next state", 32'(st[1]), 32'd1);
        chk("illegal no writes", 32'({rgw[1], frw[1]}), 32'd0);
        run[1] = 1'b0;
        wait_state(1, 3'd0, "illegal idle");

        run_one(6'h00, 6'h22, "sub run drop");
        cyc(); chk("run drop WB", 32'(st[1]), 32'd4); chk("run drop Reg", 32'(rgw[1]), 32'd1);
        cyc(); chk("run drop idle", 32'(st[1]), 32'd0);

        run_one(6'h00, 6'h20, "rst in EX");
        rst = 1'b1;
        cyc(); chk("rst EX state", 32'(st[1]), 32'd0); chk("rst EX no Reg", 32'(rgw[1]), 32'd0);
        rst = 1'b0;
        cyc();

        // FETCH_WAIT=0: add, sub, ori back to back
        regs = 0;
        op[0] = 6'h00; fn[0] = 6'h20; run[0] = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            regs += int'(rgw[0]);
            if (c == 1) chk("fw0 IR first cycle", 32'({st[0], irw[0]}), 32'b001_1);
            if (c == 4) begin op[0] = 6'h00; fn[0] = 6'h22; end
            if (c == 7) chk("fw0 sub ALU_OP", 32'(alu[0]), 32'd5);
            if (c == 8) begin op[0] = 6'h0D; fn[0] = 6'h00; end
            if (c == 9) run[0] = 1'b0;
            if (c == 11) chk("fw0 ori ALU_OP", 32'(alu[0]), 32'd1);
            if (c == 12) chk("fw0 last WB", 32'(st[0]), 32'd4);
        end
        chk("fw0 Reg_Write count", 32'(regs), 32'd3);
        cyc(); chk("fw0 idle after 12", 32'(st[0]), 32'd0);

        repeat (3) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
